// File: rtl/adder_arbiter_pkg.sv
// Package: adder_arb_pkg
// Shared types and helpers for the adder_arbiter block: the FSM state
// encoding and the requester-id width helper used by the top and the
// round-robin arbiter.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Id width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Interface: adder_if
// Connection between the arbiter (master: drives operands, reads the result)
// and the shared adder wrapper (slave: combinational sum/carry).
interface adder_if #(
  parameter int N_BIT = 32
);
  logic [N_BIT-1:0] add_a;
  logic [N_BIT-1:0] add_b;
  logic             add_cin;
  logic [N_BIT-1:0] add_sum;
  logic             add_cout;

  modport master (
    output add_a, add_b, add_cin,
    input  add_sum, add_cout
  );

  modport slave (
    input  add_a, add_b, add_cin,
    output add_sum, add_cout
  );
endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Module: rr_arbiter
// Purely combinational round-robin picker: grants the first asserted request
// at or after ptr, wrapping modulo N_REQ. Returns a one-hot grant, its index
// and an any-valid flag.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_valid
);

  // Two passes: indices at/after ptr first, then the wrapped-around ones.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_valid && req[i] && (i >= int'(ptr))) begin
        any_valid = 1'b1;
        gnt[i]    = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_valid && req[i] && (i < int'(ptr))) begin
        any_valid = 1'b1;
        gnt[i]    = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Module: adder_arbiter
// Shares one adder (reached through adder_if) between N_REQ requesters.
// Round-robin grant in IDLE, one settle/capture cycle in CALC, then the
// tagged result is held on the response channel in RESP until accepted.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// req_ready is one-hot and only asserted in IDLE; rsp_* hold steady while
// rsp_valid && !rsp_ready.
//
// Optional feature macro: ADDER_ARB_OVF_EN -- when defined, rsp_ovf carries
// the signed overflow of the captured sum; otherwise rsp_ovf is tied to 0.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N_BIT = 32,
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*N_BIT-1:0] req_a,
  input  logic [N_REQ*N_BIT-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [N_BIT-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_ovf,
  adder_if.master                adder,
  output arb_state_t             dbg_state
);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_BIT-1:0] add_a_q, add_a_d;
  logic [N_BIT-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [N_BIT-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             any_valid;
  logic [N_BIT-1:0] sel_a, sel_b;
  logic             sel_cin;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_valid (any_valid)
  );

  // One-hot operand mux driven by the grant vector.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a   = req_a[i*N_BIT +: N_BIT];
        sel_b   = req_b[i*N_BIT +: N_BIT];
        sel_cin = req_cin[i];
      end
    end
  end

  // FSM next-state and register updates: grant/latch, capture, respond.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          add_a_d   = sel_a;
          add_b_d   = sel_b;
          add_cin_d = sel_cin;
          rsp_id_d  = gnt_idx;
          state_d   = CALC;
        end
      end
      CALC: begin
        rsp_sum_d   = adder.add_sum;
        rsp_cout_d  = adder.add_cout;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Next search starts just after the requester that was served.
          ptr_d       = (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic rsp_ovf_q, rsp_ovf_d;

  // Signed overflow from the latched operands and the settled sum.
  always_comb begin
    rsp_ovf_d = rsp_ovf_q;
    if (state_q == CALC) begin
      rsp_ovf_d = (add_a_q[N_BIT-1] == add_b_q[N_BIT-1]) &&
                  (adder.add_sum[N_BIT-1] != add_a_q[N_BIT-1]);
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_ovf_q <= 1'b0;
    else        rsp_ovf_q <= rsp_ovf_d;
  end

  assign rsp_ovf = rsp_ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

  // Ready is gated by reset so every output reads 0 while rst_n is low.
  assign req_ready   = (rst_n && (state_q == IDLE)) ? gnt : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_sum     = rsp_sum_q;
  assign rsp_cout    = rsp_cout_q;
  assign adder.add_a   = add_a_q;
  assign adder.add_b   = add_b_q;
  assign adder.add_cin = add_cin_q;
  assign dbg_state   = state_q;

endmodule
